// File: rtl/ko_tracker.sv
// ko_tracker: per-player stock and respawn tracker driven by packed physics positions.
// Counts sustained blast-zone exits, decrements lives and sequences respawn/invulnerability windows.
module ko_tracker #(
    parameter logic [15:0] X_MIN          = 16'h0010,
    parameter logic [15:0] X_MAX          = 16'h0270,
    parameter logic [15:0] Y_MIN          = 16'h0008,
    parameter logic [15:0] Y_MAX          = 16'h01D0,
    parameter logic [15:0] START_LIVES    = 16'd3,
    parameter int unsigned CONFIRM        = 4,
    parameter logic [31:0] RESPAWN_CYCLES = 32'd50000000,
    parameter logic [31:0] INVULN_CYCLES  = 32'd100000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        new_game,
    input  logic [31:0] pos_in,
    output logic [31:0] lives,
    output logic        ko_pulse,
    output logic        respawn,
    output logic        invuln,
    output logic        game_over,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {
        ALIVE     = 2'b00,
        RESPAWN   = 2'b01,
        INVULN    = 2'b10,
        GAME_OVER = 2'b11
    } state_e;
    localparam int CW = (CONFIRM > 1) ? $clog2(CONFIRM) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CONFIRM - 1);
    state_e        state_q, state_d;
    logic [15:0]   lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   timer_q, timer_d;
    logic          ko_q, ko_d;
    logic          oob, counting, windowed, timer_last, ko;
    assign oob = (pos_in[31:16] < X_MIN) | (pos_in[31:16] > X_MAX) |
                 (pos_in[15:0] < Y_MIN) | (pos_in[15:0] > Y_MAX);
    assign counting   = (state_q == ALIVE) | (state_q == INVULN);
    assign windowed   = (state_q == RESPAWN) | (state_q == INVULN);
    assign timer_last = windowed &
                        (timer_q == ((state_q == RESPAWN) ? RESPAWN_CYCLES : INVULN_CYCLES) - 32'd1);
    assign ko = enable & counting & oob & (cnt_q == CNT_LAST);
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ALIVE;
            lives_q <= START_LIVES;
            cnt_q   <= '0;
            timer_q <= '0;
            ko_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            ko_q    <= ko_d;
        end
    end
    // A KO outranks window expiry, so a KO inside INVULN cuts the window short.
    always_comb begin
        state_d = new_game ? ALIVE :
                  !enable  ? state_q :
                  ko       ? ((lives_q > 16'd1) ? RESPAWN : GAME_OVER) :
                  (timer_last && state_q == RESPAWN) ? INVULN :
                  (timer_last && state_q == INVULN)  ? ALIVE : state_q;
    end
    always_comb begin
        timer_d = new_game ? '0 :
                  !enable  ? timer_q :
                  (ko || timer_last || !windowed) ? '0 : timer_q + 32'd1;
        cnt_d   = new_game ? '0 :
                  !enable  ? cnt_q :
                  (counting && oob && !ko) ? cnt_q + CW'(1) : '0;
        lives_d = new_game ? START_LIVES :
                  (ko && lives_q != 16'd0) ? lives_q - 16'd1 : lives_q;
        ko_d    = ko & ~new_game;
    end
    always_comb begin
        lives     = {16'h0000, lives_q};
        ko_pulse  = ko_q;
        respawn   = state_q == RESPAWN;
        invuln    = state_q == INVULN;
        game_over = state_q == GAME_OVER;
        state_dbg = state_q;
    end
endmodule

// File: tb/tb_ko_tracker.sv
// tb_ko_tracker: scenario tasks plus randomized traffic checked against a cycle-level game model.
module tb_ko_tracker;
    localparam int CONFIRM = 4;
    localparam int RC      = 8;
    localparam int IC      = 6;
    localparam int START   = 3;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        new_game = 1'b0;
    logic [31:0] pos_in = 32'h0160_00FA;
    logic [31:0] lives;
    logic        ko_pulse, respawn, invuln, game_over;
    logic [1:0]  state_dbg;
    int n_cmp = 0;
    int n_bad = 0;
    int m_state, m_lives, m_run, m_left, m_cyc;
    bit m_ko;
    ko_tracker #(
        .START_LIVES(16'(START)),
        .CONFIRM(CONFIRM),
        .RESPAWN_CYCLES(32'(RC)),
        .INVULN_CYCLES(32'(IC))
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .new_game(new_game),
        .pos_in(pos_in), .lives(lives), .ko_pulse(ko_pulse), .respawn(respawn),
        .invuln(invuln), .game_over(game_over), .state_dbg(state_dbg)
    );
    always #5 clock = ~clock;
    function automatic bit oob_of(input logic [31:0] p);
        return p[31:16] < 16'h0010 || p[31:16] > 16'h0270 || p[15:0] < 16'h0008 || p[15:0] > 16'h01D0;
    endfunction
    function automatic logic [37:0] obs_v();
        return {lives, state_dbg, ko_pulse, respawn, invuln, game_over};
    endfunction
    function automatic logic [37:0] exp_v();
        return {16'h0, 16'(m_lives), 2'(m_state), m_ko, m_state == 1, m_state == 2, m_state == 3};
    endfunction
    // Model: state 0 alive, 1 respawn, 2 invuln, 3 game over; m_left counts window cycles remaining.
    task automatic tick();
        int s;
        s = m_state;
        m_ko = 1'b0;
        if (!reset || new_game) begin
            m_state = 0; m_lives = START; m_run = 0; m_left = 0;
        end else if (enable) begin
            if (s == 0 || s == 2) begin
                m_run = oob_of(pos_in) ? m_run + 1 : 0;
                if (m_run == CONFIRM) begin
                    m_ko = 1'b1; m_run = 0;
                    if (m_lives > 1) begin m_lives--; m_state = 1; m_left = RC; end
                    else begin m_lives = 0; m_state = 3; end
                end else if (s == 2) begin
                    m_left--;
                    if (m_left == 0) m_state = 0;
                end
            end else if (s == 1) begin
                m_left--;
                if (m_left == 0) begin m_state = 2; m_left = IC; end
            end
        end
        @(posedge clock);
        #1;
        m_cyc++;
    endtask
    task automatic do_reset();
        reset = 1'b0; new_game = 1'b0; enable = 1'b1;
        tick();
        reset = 1'b1;
    endtask
    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (obs_v() !== {32'd3, 2'b00, 4'b0000}) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", obs_v(), {32'd3, 2'b00, 4'b0000});
        end
        reset = 1'b1;
    endtask
    task automatic test_in_bounds();
        int kos = 0;
        pos_in = 32'h0160_00FA;
        for (int i = 0; i < 100; i++) begin
            tick();
            kos += int'(ko_pulse);
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++; $display("FAIL in_bounds cyc %0d: got %h want %h", m_cyc, obs_v(), exp_v());
            end
        end
        n_cmp++;
        if (kos != 0 || lives !== 32'd3 || state_dbg !== 2'b00) begin
            n_bad++; $display("FAIL in_bounds_end: ko %0d lives %h st %b want 0/3/00", kos, lives, state_dbg);
        end
    endtask
    task automatic test_confirm();
        pos_in = 32'h0280_00FA;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (ko_pulse !== 1'b0 || obs_v() !== exp_v()) begin
                n_bad++; $display("FAIL short_burst cyc %0d: got %h want %h", m_cyc, obs_v(), exp_v());
            end
        end
        pos_in = 32'h0160_00FA;
        tick();
        pos_in = 32'h0280_00FA;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (ko_pulse !== (i == 4)) begin
                n_bad++; $display("FAIL confirm_latency burst cyc %0d: ko %b want %b", i, ko_pulse, i == 4);
            end
        end
        n_cmp++;
        if (obs_v() !== {32'd2, 2'b01, 4'b1100}) begin
            n_bad++; $display("FAIL first_ko: got %h want %h", obs_v(), {32'd2, 2'b01, 4'b1100});
        end
        pos_in = 32'h0160_00FA;
    endtask
    task automatic test_windows();
        int cnt = 0;
        for (int i = 0; i < 50 && respawn; i++) begin cnt++; tick(); end
        n_cmp++;
        if (cnt != RC) begin n_bad++; $display("FAIL respawn_len: got %0d want %0d", cnt, RC); end
        cnt = 0;
        for (int i = 0; i < 50 && invuln; i++) begin cnt++; tick(); end
        n_cmp++;
        if (cnt != IC) begin n_bad++; $display("FAIL invuln_len: got %0d want %0d", cnt, IC); end
        n_cmp++;
        if (obs_v() !== exp_v() || state_dbg !== 2'b00) begin
            n_bad++; $display("FAIL back_alive: got %h want %h", obs_v(), exp_v());
        end
    endtask
    task automatic test_stall();
        int cnt = 0;
        pos_in = 32'h0280_00FA;
        for (int i = 0; i < 4; i++) tick();
        pos_in = 32'h0160_00FA;
        for (int i = 0; i < 60 && respawn; i++) begin
            cnt++;
            enable = !(i >= 2 && i < 7);
            tick();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++; $display("FAIL stall cyc %0d: got %h want %h", m_cyc, obs_v(), exp_v());
            end
        end
        enable = 1'b1;
        n_cmp++;
        if (cnt != RC + 5) begin n_bad++; $display("FAIL stall_len: got %0d want %0d", cnt, RC + 5); end
        for (int i = 0; i < 20 && state_dbg != 2'b00; i++) tick();
        n_cmp++;
        if (obs_v() !== {32'd1, 2'b00, 4'b0000}) begin
            n_bad++; $display("FAIL stall_end: got %h want %h", obs_v(), {32'd1, 2'b00, 4'b0000});
        end
    endtask
    task automatic test_game_over();
        int kos = 0;
        do_reset();
        pos_in = 32'h0100_0004;
        for (int i = 0; i < 80; i++) begin
            tick();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++; $display("FAIL game_over_seq cyc %0d: got %h want %h", m_cyc, obs_v(), exp_v());
            end
            if (ko_pulse) begin
                n_cmp++;
                if (lives !== 32'(2 - kos)) begin
                    n_bad++; $display("FAIL ko_lives #%0d: got %0d want %0d", kos, lives, 2 - kos);
                end
                kos++;
            end
        end
        n_cmp++;
        if (kos != 3 || obs_v() !== {32'd0, 2'b11, 4'b0001}) begin
            n_bad++; $display("FAIL game_over_end: kos %0d got %h want 3/%h", kos, obs_v(), {32'd0, 2'b11, 4'b0001});
        end
    endtask
    task automatic test_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        n_cmp++;
        if (obs_v() !== {32'd3, 2'b00, 4'b0000}) begin
            n_bad++; $display("FAIL new_game_reload: got %h want %h", obs_v(), {32'd3, 2'b00, 4'b0000});
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (ko_pulse !== (k == 4)) begin
                n_bad++; $display("FAIL new_game_recount k %0d: ko %b want %b", k, ko_pulse, k == 4);
            end
        end
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        n_cmp++;
        if (obs_v() !== {32'd3, 2'b00, 4'b0000}) begin
            n_bad++; $display("FAIL ko_vs_new_game: got %h want %h", obs_v(), {32'd3, 2'b00, 4'b0000});
        end
    endtask
    task automatic test_reset_mid();
        do_reset();
        pos_in = 32'h0280_00FA;
        for (int i = 0; i < 4; i++) tick();
        pos_in = 32'h0160_00FA;
        for (int i = 0; i < 20 && !invuln; i++) tick();
        tick();
        tick();
        n_cmp++;
        if (invuln !== 1'b1) begin n_bad++; $display("FAIL reach_invuln: got %b want 1", invuln); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_cmp++;
        if (obs_v() !== {32'd3, 2'b00, 4'b0000}) begin
            n_bad++; $display("FAIL reset_mid: got %h want %h", obs_v(), {32'd3, 2'b00, 4'b0000});
        end
    endtask
    task automatic test_boundaries();
        logic [31:0] bpos [8];
        bit          bout [8];
        bpos = '{32'h0010_00FA, 32'h000F_00FA, 32'h0270_00FA, 32'h0271_00FA,
                 32'h0100_0008, 32'h0100_0007, 32'h0100_01D0, 32'h0100_01D1};
        bout = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            do_reset();
            pos_in = bpos[i];
            for (int k = 0; k < 4; k++) tick();
            n_cmp++;
            if (ko_pulse !== bout[i] || obs_v() !== exp_v()) begin
                n_bad++; $display("FAIL boundary pos %h: ko %b want %b", bpos[i], ko_pulse, bout[i]);
            end
        end
    endtask
    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3)
                pos_in = ($urandom_range(0, 1) == 0) ? $urandom()
                       : {16'($urandom_range(16'h0010, 16'h0270)), 16'($urandom_range(16'h0008, 16'h01D0))};
            enable   = $urandom_range(0, 9) != 0;
            new_game = $urandom_range(0, 99) == 0;
            reset    = $urandom_range(0, 299) != 0;
            tick();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++; $display("FAIL random cyc %0d: got %h want %h", m_cyc, obs_v(), exp_v());
            end
        end
        reset = 1'b1; enable = 1'b1; new_game = 1'b0;
    endtask
    initial begin
        m_state = 0; m_lives = START; m_run = 0; m_left = 0; m_ko = 1'b0; m_cyc = 0;
        test_reset();
        test_in_bounds();
        test_confirm();
        test_windows();
        test_stall();
        test_game_over();
        test_new_game();
        test_reset_mid();
        test_boundaries();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
